clear_banner_ctrl: RTL and testbench
====================================

Name: clear_banner_ctrl

Overview:
- Sequences the stage-clear banner image ROM (12-bit RGB, 18-bit address, 1-cycle registered read) for the VGA pixel pipeline.
- Triggered by game logic, it runs a timed show-then-blink sequence counted in video frames. For each pixel inside the banner window it generates the ROM address and produces an overlay colour/enable pair, with transparency keying, for the layer mixer.

Parameters:
- DATA_WIDTH, 12, ROM pixel width (4:4:4 RGB).
- ADDR_WIDTH, 18, ROM address width.
- IMG_W, 320, banner width in pixels.
- IMG_H, 204, banner height in pixels (IMG_W*IMG_H <= 65536).
- X0, 160, left edge of banner window in screen x.
- Y0, 138, top edge of banner window in screen y.
- SHOW_FRAMES, 120, frames of solid display (>=1).
- BLINK_FRAMES, 60, frames of blinking display (>=1).
- BLINK_PERIOD, 8, frames per blink half-period (>=1).
- TRANSPARENT, 12'h0F0, ROM colour treated as see-through.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  single-cycle start request.
- abort  in  1  single-cycle cancel request.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- pixel_x  in  10  current screen x.
- pixel_y  in  10  current screen y.
- rom_addr  out  ADDR_WIDTH  registered address to banner ROM.
- rom_data  in  DATA_WIDTH  ROM output, valid one edge after rom_addr.
- overlay_rgb  out  DATA_WIDTH  banner colour, 0 when not enabled.
- overlay_en  out  1  banner pixel is opaque and visible.
- busy  out  1  high in SHOW and BLINK.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, active-high): state=IDLE, all counters 0, blink phase 0, rom_addr=0, overlay_rgb=0, overlay_en=0, busy=0, done=0, window pipeline flags 0.
- Address stage, every cycle regardless of state:
  - in_win = (X0 <= pixel_x < X0+IMG_W) && (Y0 <= pixel_y < Y0+IMG_H).
  - At edge k: rom_addr <= in_win ? (pixel_y-Y0)*IMG_W + (pixel_x-X0) : 0. Arithmetic is unsigned, width ADDR_WIDTH, with no wrap inside the window.
  - in_win is delayed through 2 register stages, aligned with rom_data.
- Output stage at edge k+2 (latency 2 cycles from pixel_x/pixel_y to overlay outputs; the mixer delays other layers by 2):
  - overlay_en <= visible && in_win_d2 && (rom_data != TRANSPARENT).
  - overlay_rgb <= overlay_en_next ? rom_data : 0.
- visible: 1 in SHOW; equals blink phase in BLINK; 0 otherwise.
- State machine; frame counter fcnt, blink counter bcnt:
  - IDLE: on trigger -> SHOW, fcnt=0, bcnt=0, phase=0.
  - SHOW: on frame_tick, fcnt++. When frame_tick && fcnt==SHOW_FRAMES-1 -> BLINK, fcnt=0, bcnt=0, phase=0 (hidden first).
  - BLINK: on frame_tick, fcnt++ and bcnt++. When bcnt==BLINK_PERIOD-1, phase toggles and bcnt=0. When frame_tick && fcnt==BLINK_FRAMES-1 -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- busy=1 in SHOW/BLINK only. done is registered and high only in DONE.
- Simultaneous and boundary events:
  - abort in SHOW/BLINK/DONE: -> IDLE next edge, no done pulse, counters cleared.
  - abort && trigger in the same cycle: abort wins, state IDLE.
  - trigger while busy: ignored, no restart.
  - trigger in DONE: ignored; a new run needs trigger in IDLE.
  - frame_tick in the same cycle as trigger: not counted (counting starts in SHOW).
  - Pixels outside the window: rom_addr=0, overlay_en=0 regardless of state.
  - Reset mid-run: immediate return to reset values, no done pulse.
- Visibility changes only on frame_tick edges, so no mid-frame tearing within a sequence.

Test Plan:
- Reset then idle; sweep full frame -> overlay_en never 1, rom_addr=0 outside window; pixel (160,138) gives rom_addr=0, (479,341) gives rom_addr=65279.
- Trigger, SHOW_FRAMES=2, BLINK_FRAMES=4, BLINK_PERIOD=2:
  - busy rises next edge.
  - Solid for 2 ticks, then hidden 2 ticks, visible 2 ticks.
  - done pulses 1 cycle after the 6th tick; busy falls the same edge.
- Pixel (170,140) in SHOW with ROM word 12'hF00 -> overlay_en=1, overlay_rgb=12'hF00 exactly 2 cycles later; same pixel with ROM 12'h0F0 -> overlay_en=0, overlay_rgb=0.
- abort asserted in BLINK, and separately abort together with trigger in IDLE -> state IDLE, busy=0, done never pulses.
- Second trigger during SHOW -> no restart; total sequence length unchanged (6 ticks).
- Async reset asserted between clock edges mid-SHOW -> outputs zero immediately without a clock edge; trigger after release starts a fresh full sequence.

Source files
------------

// File: rtl/clear_banner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clear_banner_ctrl
//  Brief    : Stage-clear banner sequencer. It addresses the banner image ROM
//             for pixels inside the banner window and keys out transparent
//             pixels. Visibility follows a frame-counted show-then-blink run.
//  Revision : 1.0 - initial release
// ============================================================================
module clear_banner_ctrl #(
  parameter int          DATA_WIDTH   = 12,
  parameter int          ADDR_WIDTH   = 18,
  parameter int          IMG_W        = 320,
  parameter int          IMG_H        = 204,
  parameter int          X0           = 160,
  parameter int          Y0           = 138,
  parameter int          SHOW_FRAMES  = 120,
  parameter int          BLINK_FRAMES = 60,
  parameter int          BLINK_PERIOD = 8,
  parameter logic [11:0] TRANSPARENT  = 12'h0F0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  trigger_i,
  input  logic                  abort_i,
  input  logic                  frame_tick_i,
  input  logic [9:0]            pixel_x_i,
  input  logic [9:0]            pixel_y_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] overlay_rgb_o,
  output logic                  overlay_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CNT_W = 16;

  // Window bounds widened by one bit so X0+IMG_W / Y0+IMG_H cannot overflow.
  localparam logic [10:0]           c_x_lo  = 11'(X0);
  localparam logic [10:0]           c_x_hi  = 11'(X0 + IMG_W);
  localparam logic [10:0]           c_y_lo  = 11'(Y0);
  localparam logic [10:0]           c_y_hi  = 11'(Y0 + IMG_H);
  localparam logic [ADDR_WIDTH-1:0] c_x0    = ADDR_WIDTH'(X0);
  localparam logic [ADDR_WIDTH-1:0] c_y0    = ADDR_WIDTH'(Y0);
  localparam logic [ADDR_WIDTH-1:0] c_img_w = ADDR_WIDTH'(IMG_W);
  localparam logic [CNT_W-1:0] c_show_last  = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_per_last   = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] c_transp = DATA_WIDTH'(TRANSPARENT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLINK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             phase_q, phase_d;

  logic                  win_d1_q, win_d2_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [DATA_WIDTH-1:0] overlay_rgb_q;
  logic                  overlay_en_q;

  logic                  w_in_win;
  logic [ADDR_WIDTH-1:0] w_dx, w_dy, w_addr;
  logic                  w_visible;
  logic                  w_en_next;

  assign w_in_win = ({1'b0, pixel_x_i} >= c_x_lo) && ({1'b0, pixel_x_i} < c_x_hi) &&
                    ({1'b0, pixel_y_i} >= c_y_lo) && ({1'b0, pixel_y_i} < c_y_hi);
  assign w_dx     = ADDR_WIDTH'(pixel_x_i) - c_x0;
  assign w_dy     = ADDR_WIDTH'(pixel_y_i) - c_y0;
  assign w_addr   = (w_dy * c_img_w) + w_dx;

  // Blink phase only gates the image while blinking; phase 0 means hidden.
  assign w_visible = (state_q == S_SHOW) || ((state_q == S_BLINK) && phase_q);
  assign w_en_next = w_visible && win_d2_q && (rom_data_i != c_transp);

  // Address stage plus window-flag delay line matching the ROM read latency.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rom_addr_q <= '0;
      win_d1_q   <= 1'b0;
      win_d2_q   <= 1'b0;
    end else begin
      rom_addr_q <= w_in_win ? w_addr : '0;
      win_d1_q   <= w_in_win;
      win_d2_q   <= win_d1_q;
    end
  end

  // Output stage: keyed overlay colour and enable, aligned with rom_data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overlay_en_q  <= 1'b0;
      overlay_rgb_q <= '0;
    end else begin
      overlay_en_q  <= w_en_next;
      overlay_rgb_q <= w_en_next ? rom_data_i : '0;
    end
  end

  // Sequencer state, frame counter, blink counter and blink phase registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic; abort has priority over every other event.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (trigger_i && !abort_i) begin
          state_d = S_SHOW;
          fcnt_d  = '0;
          bcnt_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_SHOW: begin
        if (abort_i) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
          bcnt_d  = '0;
          phase_d = 1'b0;
        end else if (frame_tick_i) begin
          if (fcnt_q == c_show_last) begin
            state_d = S_BLINK;
            fcnt_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      S_BLINK: begin
        if (abort_i) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
          bcnt_d  = '0;
          phase_d = 1'b0;
        end else if (frame_tick_i) begin
          if (fcnt_q == c_blink_last) begin
            state_d = S_DONE;
            fcnt_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
            if (bcnt_q == c_per_last) begin
              bcnt_d  = '0;
              phase_d = ~phase_q;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
        bcnt_d  = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  assign rom_addr_o    = rom_addr_q;
  assign overlay_en_o  = overlay_en_q;
  assign overlay_rgb_o = overlay_rgb_q;
  assign busy_o        = (state_q == S_SHOW) || (state_q == S_BLINK);
  assign done_o        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_clear_banner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clear_banner_ctrl
//  Brief    : Directed self-checking bench for clear_banner_ctrl with a short
//             2 show / 4 blink / period 2 frame sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clear_banner_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        abort = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [17:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] overlay_rgb;
  logic        overlay_en;
  logic        busy;
  logic        done;

  logic [11:0] rom_val = 12'hF00;
  int          total = 0;
  int          bad = 0;

  clear_banner_ctrl #(
    .SHOW_FRAMES (2),
    .BLINK_FRAMES(4),
    .BLINK_PERIOD(2)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .trigger_i    (trigger),
    .abort_i      (abort),
    .frame_tick_i (frame_tick),
    .pixel_x_i    (pixel_x),
    .pixel_y_i    (pixel_y),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .overlay_rgb_o(overlay_rgb),
    .overlay_en_o (overlay_en),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Banner ROM stand-in: registered read returning the current test word.
  always @(posedge clk) rom_data <= rom_val;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (rom_addr !== 18'd0)  begin bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    total++; if (overlay_en !== 1'b0) begin bad++; $display("FAIL reset_overlay_en got=%b exp=0", overlay_en); end
    total++; if (overlay_rgb !== 12'h000) begin bad++; $display("FAIL reset_overlay_rgb got=%h exp=000", overlay_rgb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_window();
    int px[7] = '{160, 479, 161, 160, 159, 480, 479};
    int py[7] = '{138, 341, 138, 139, 138, 341, 342};
    int pa[7] = '{0, 65279, 1, 320, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      pixel_x = 10'(px[i]);
      pixel_y = 10'(py[i]);
      @(negedge clk);
      total++;
      if (rom_addr !== 18'(pa[i])) begin
        bad++; $display("FAIL win_addr(%0d,%0d) got=%0d exp=%0d", px[i], py[i], rom_addr, pa[i]);
      end
    end
    // Coarse idle sweep of the whole screen.
    for (int y = 0; y < 480; y += 37) begin
      for (int x = 0; x < 640; x += 23) begin
        int ex;
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        if (x >= 160 && x < 480 && y >= 138 && y < 342) ex = (y - 138) * 320 + (x - 160);
        else ex = 0;
        @(negedge clk);
        total++;
        if (rom_addr !== 18'(ex)) begin
          bad++; $display("FAIL sweep_addr(%0d,%0d) got=%0d exp=%0d", x, y, rom_addr, ex);
        end
        total++;
        if (overlay_en !== 1'b0) begin
          bad++; $display("FAIL sweep_idle_en(%0d,%0d) got=%b exp=0", x, y, overlay_en);
        end
      end
    end
  endtask

  // Runs an already-triggered sequence: 2 solid, 2 hidden, 2 visible frames.
  task automatic test_full_sequence(input string tag);
    logic exp_vis[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      repeat (6) @(negedge clk);
      total++;
      if (overlay_en !== exp_vis[i]) begin
        bad++; $display("FAIL %s_vis frame=%0d got=%b exp=%b", tag, i, overlay_en, exp_vis[i]);
      end
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL %s_busy frame=%0d got busy=%b done=%b exp busy=1 done=0", tag, i, busy, done);
      end
      pulse_tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_done got done=%b busy=%b exp done=1 busy=0", tag, done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s_done_width got=%b exp=0", tag, done);
    end
  endtask

  task automatic test_sequence();
    pixel_x = 10'd170;
    pixel_y = 10'd140;
    rom_val = 12'hF00;
    pulse_trigger();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL seq_busy_rise got=%b exp=1", busy); end
    test_full_sequence("seq");
  endtask

  task automatic test_pixel();
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    rom_val = 12'hF00;
    pulse_trigger();
    repeat (4) @(negedge clk);
    total++;
    if (overlay_en !== 1'b0) begin bad++; $display("FAIL pix_outside_en got=%b exp=0", overlay_en); end
    pixel_x = 10'd170;
    pixel_y = 10'd140;
    @(negedge clk);
    total++;
    if (rom_addr !== 18'd650) begin bad++; $display("FAIL pix_addr got=%0d exp=650", rom_addr); end
    @(negedge clk);
    total++;
    if (overlay_en !== 1'b0) begin bad++; $display("FAIL pix_latency_early got=%b exp=0", overlay_en); end
    @(negedge clk);
    total++;
    if (overlay_en !== 1'b1 || overlay_rgb !== 12'hF00) begin
      bad++; $display("FAIL pix_opaque got en=%b rgb=%h exp en=1 rgb=f00", overlay_en, overlay_rgb);
    end
    rom_val = 12'h0F0;
    repeat (3) @(negedge clk);
    total++;
    if (overlay_en !== 1'b0 || overlay_rgb !== 12'h000) begin
      bad++; $display("FAIL pix_transparent got en=%b rgb=%h exp en=0 rgb=000", overlay_en, overlay_rgb);
    end
    rom_val = 12'hF00;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL pix_abort_show got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    pixel_x = 10'd170;
    pixel_y = 10'd140;
    pulse_trigger();
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      pulse_tick();
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_blink got busy=%b done=%b exp 0 0", busy, done);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL abort_idle_hold cyc=%0d got busy=%b done=%b exp 0 0", i, busy, done);
      end
    end
    abort = 1'b1;
    trigger = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    trigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL abort_with_trigger cyc=%0d got busy=%b done=%b exp 0 0", i, busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    pulse_trigger();
    repeat (2) @(negedge clk);
    pulse_tick();
    pulse_trigger();
    for (int i = 2; i <= 5; i++) begin
      repeat (2) @(negedge clk);
      pulse_tick();
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL retrig_tick%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
      end
    end
    repeat (2) @(negedge clk);
    pulse_tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL retrig_len got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    pixel_x = 10'd170;
    pixel_y = 10'd140;
    rom_val = 12'hF00;
    pulse_trigger();
    repeat (6) @(negedge clk);
    total++;
    if (overlay_en !== 1'b1) begin bad++; $display("FAIL areset_pre_en got=%b exp=1", overlay_en); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL areset_ctrl got busy=%b done=%b exp 0 0", busy, done);
    end
    total++;
    if (overlay_en !== 1'b0 || overlay_rgb !== 12'h000 || rom_addr !== 18'd0) begin
      bad++; $display("FAIL areset_data got en=%b rgb=%h addr=%0d exp 0 000 0", overlay_en, overlay_rgb, rom_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_trigger();
    test_full_sequence("areset");
  endtask

  initial begin
    test_reset();
    test_window();
    test_sequence();
    test_pixel();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
